// File: rtl/count_req_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_req_conditioner_if
//  Description : Request/pulse/status bundle between a request source and the
//                occupancy-counter request conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface count_req_conditioner_if;
  logic       inc_req;
  logic       dec_req;
  logic [3:0] count_in;
  logic       clr_err;
  logic       up;
  logic       down;
  logic       overflow_err;
  logic       underflow_err;
  logic       busy;

  modport master (
    output inc_req, dec_req, count_in, clr_err,
    input  up, down, overflow_err, underflow_err, busy
  );

  modport slave (
    input  inc_req, dec_req, count_in, clr_err,
    output up, down, overflow_err, underflow_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/count_req_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : count_req_conditioner
//  Description : Synchronizes and edge-detects asynchronous inc/dec requests,
//                spaces them by a hold-off window and emits single-cycle
//                up/down pulses, refusing moves that would wrap the counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_req_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 3,
  parameter int MAX_COUNT   = 15
) (
  input  logic                    clk,
  input  logic                    n_rst,
  count_req_conditioner_if.slave  bus
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int WW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Bit 0 is the increment channel, bit 1 the decrement channel.
  logic [1:0]    req_w;
  logic [1:0]    rise_w;
  logic [1:0]    edge_q, edge_d;
  logic [WW-1:0] warm_q, warm_d;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pend_inc_q, pend_inc_d;
  logic          pend_dec_q, pend_dec_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          busy_q, busy_d;
  logic          inc_w, dec_w;

  assign req_w = {bus.dec_req, bus.inc_req};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Synchronizer chain followed by the previous-sample flop for rise detection.
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], req_w[gi]};
      prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and previous-sample registers.
    always_ff @(posedge clk) begin
      if (!n_rst) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        prev_q <= prev_d;
      end
    end

    assign rise_w[gi] = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  assign inc_w = edge_q[0] | pend_inc_q;
  assign dec_w = edge_q[1] | pend_dec_q;

  // Next-state logic: warm-up masking, pending merge, IDLE/HOLD decisions, flags.
  always_comb begin
    // The chain was cleared by reset, so a request held high across release
    // looks like a rise until the chain has refilled; mask rises until then.
    warm_d     = (warm_q != '0) ? warm_q - WW'(1) : warm_q;
    edge_d     = (warm_q == '0) ? rise_w : 2'b00;
    state_d    = state_q;
    hold_d     = hold_q;
    pend_inc_d = pend_inc_q;
    pend_dec_d = pend_dec_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    ovf_d      = ovf_q & ~bus.clr_err;
    unf_d      = unf_q & ~bus.clr_err;

    case (state_q)
      ST_IDLE: begin
        if (inc_w && dec_w) begin
          pend_inc_d = 1'b0;
          pend_dec_d = 1'b0;
        end else if (inc_w) begin
          pend_inc_d = 1'b0;
          if (bus.count_in == 4'(MAX_COUNT)) begin
            ovf_d = 1'b1;
          end else begin
            up_d    = 1'b1;
            state_d = ST_HOLD;
            hold_d  = HW'(HOLDOFF - 1);
          end
        end else if (dec_w) begin
          pend_dec_d = 1'b0;
          if (bus.count_in == 4'd0) begin
            unf_d = 1'b1;
          end else begin
            down_d  = 1'b1;
            state_d = ST_HOLD;
            hold_d  = HW'(HOLDOFF - 1);
          end
        end
      end
      ST_HOLD: begin
        pend_inc_d = pend_inc_q | edge_q[0];
        pend_dec_d = pend_dec_q | edge_q[1];
        if (hold_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_HOLD) | pend_inc_d | pend_dec_d;
  end

  // State, pending, output and flag registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      warm_q     <= WW'(SYNC_STAGES + 1);
      edge_q     <= 2'b00;
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      pend_inc_q <= 1'b0;
      pend_dec_q <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      warm_q     <= warm_d;
      edge_q     <= edge_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      pend_inc_q <= pend_inc_d;
      pend_dec_q <= pend_dec_d;
      up_q       <= up_d;
      down_q     <= down_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.up            = up_q;
  assign bus.down          = down_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
  assign bus.busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_count_req_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_req_conditioner
//  Description : Directed bench for count_req_conditioner; expected up/down
//                pulses are queued with their cycle and checked by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_req_conditioner;

  typedef struct {
    bit is_up;
    int cyc;
  } exp_t;

  logic clk;
  logic n_rst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   base;
  exp_t exp_q[$];

  count_req_conditioner_if bus_if ();

  count_req_conditioner #(
    .SYNC_STAGES (2),
    .HOLDOFF     (3),
    .MAX_COUNT   (15)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_up, input int c);
    exp_t e;
    e.is_up = is_up;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every up/down pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus_if.up === 1'b1 || bus_if.down === 1'b1) begin
      tests++;
      if (bus_if.up === 1'b1 && bus_if.down === 1'b1) begin
        fails++;
        $display("FAIL up_down_together: got both high expected one (cycle %0d)", cyc);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got up=%0b down=%0b expected none (cycle %0d)",
                 bus_if.up, bus_if.down, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_up != bus_if.up || e.cyc != cyc) begin
          fails++;
          $display("FAIL pulse: got up=%0b at cycle %0d expected up=%0b at cycle %0d",
                   bus_if.up, cyc, e.is_up, e.cyc);
        end
      end
    end
  end

  initial begin
    n_rst           = 1'b0;
    bus_if.inc_req  = 1'b1;
    bus_if.dec_req  = 1'b0;
    bus_if.count_in = 4'd0;
    bus_if.clr_err  = 1'b0;

    // Reset with a request held high.
    step(2);
    chk("rst_up", bus_if.up, 0);
    chk("rst_down", bus_if.down, 0);
    chk("rst_ovf", bus_if.overflow_err, 0);
    chk("rst_unf", bus_if.underflow_err, 0);
    chk("rst_busy", bus_if.busy, 0);
    n_rst = 1'b1;
    step(8);
    chk("held_req_no_edge_busy", bus_if.busy, 0);
    bus_if.inc_req = 1'b0;
    step(4);

    // Single increment: pulse 4 cycles after drive, busy for 3 cycles.
    bus_if.count_in = 4'd5;
    base = cyc;
    bus_if.inc_req = 1'b1;
    push(1'b1, base + 4);
    step(2);
    bus_if.inc_req = 1'b0;
    step(1);
    chk("single_busy_before", bus_if.busy, 0);
    step(1);
    chk("single_busy_first", bus_if.busy, 1);
    step(2);
    chk("single_busy_last", bus_if.busy, 1);
    step(1);
    chk("single_busy_after", bus_if.busy, 0);
    step(4);

    // Back-to-back: three edges, the last two merge into one pending.
    bus_if.count_in = 4'd0;
    base = cyc;
    push(1'b1, base + 4);
    push(1'b1, base + 8);
    bus_if.inc_req = 1'b1; step(1);
    bus_if.inc_req = 1'b0; step(1);
    bus_if.inc_req = 1'b1; step(1);
    bus_if.inc_req = 1'b0; step(1);
    bus_if.inc_req = 1'b1; step(1);
    bus_if.inc_req = 1'b0;
    step(12);

    // Overflow at MAX_COUNT, sticky, then cleared.
    bus_if.count_in = 4'd15;
    bus_if.inc_req = 1'b1;
    step(2);
    bus_if.inc_req = 1'b0;
    step(1);
    chk("ovf_not_yet", bus_if.overflow_err, 0);
    step(1);
    chk("ovf_set", bus_if.overflow_err, 1);
    step(4);
    chk("ovf_sticky", bus_if.overflow_err, 1);
    chk("ovf_no_unf", bus_if.underflow_err, 0);
    bus_if.clr_err = 1'b1;
    step(1);
    chk("ovf_cleared", bus_if.overflow_err, 0);
    bus_if.clr_err = 1'b0;
    step(2);

    // Set and clear in the same cycle: set wins.
    bus_if.inc_req = 1'b1;
    step(2);
    bus_if.inc_req = 1'b0;
    step(1);
    bus_if.clr_err = 1'b1;
    step(1);
    chk("set_beats_clr", bus_if.overflow_err, 1);
    step(1);
    chk("clr_after_set", bus_if.overflow_err, 0);
    bus_if.clr_err = 1'b0;
    step(2);

    // Underflow at zero.
    bus_if.count_in = 4'd0;
    bus_if.dec_req = 1'b1;
    step(2);
    bus_if.dec_req = 1'b0;
    step(1);
    chk("unf_not_yet", bus_if.underflow_err, 0);
    step(1);
    chk("unf_set", bus_if.underflow_err, 1);
    chk("unf_no_ovf", bus_if.overflow_err, 0);
    step(3);
    chk("unf_sticky", bus_if.underflow_err, 1);
    bus_if.clr_err = 1'b1;
    step(1);
    chk("unf_cleared", bus_if.underflow_err, 0);
    bus_if.clr_err = 1'b0;
    step(2);

    // Simultaneous inc/dec cancel.
    bus_if.count_in = 4'd7;
    bus_if.inc_req = 1'b1;
    bus_if.dec_req = 1'b1;
    step(2);
    bus_if.inc_req = 1'b0;
    bus_if.dec_req = 1'b0;
    step(6);
    chk("cancel_ovf", bus_if.overflow_err, 0);
    chk("cancel_unf", bus_if.underflow_err, 0);
    chk("cancel_busy", bus_if.busy, 0);

    // Opposite request arrives during HOLD and is serviced after it.
    base = cyc;
    bus_if.inc_req = 1'b1;
    push(1'b1, base + 4);
    push(1'b0, base + 8);
    step(2);
    bus_if.inc_req = 1'b0;
    bus_if.dec_req = 1'b1;
    step(2);
    bus_if.dec_req = 1'b0;
    step(10);

    // Reset during HOLD with a decrement pending: no down afterwards.
    base = cyc;
    bus_if.inc_req = 1'b1;
    push(1'b1, base + 4);
    step(1);
    bus_if.dec_req = 1'b1;
    step(1);
    bus_if.inc_req = 1'b0;
    step(1);
    bus_if.dec_req = 1'b0;
    step(2);
    chk("midhold_busy", bus_if.busy, 1);
    n_rst = 1'b0;
    step(1);
    chk("midhold_rst_busy", bus_if.busy, 0);
    chk("midhold_rst_up", bus_if.up, 0);
    chk("midhold_rst_down", bus_if.down, 0);
    n_rst = 1'b1;
    step(12);

    chk("expected_pulses_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
